// File: rtl/dsp_sys_arr_pkg.sv
// Shared types and helpers for the systolic-array result drain path.
package dsp_sys_arr_pkg;

  localparam int WORD_W = 32;

  // One IEEE-754 single-precision result word.
  typedef logic [WORD_W-1:0] word_t;

  // Streamer control states.
  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } strm_state_t;

  // Number of beats needed to drain an m x k matrix over a bw-word stream.
  function automatic int beats(input int m, input int k, input int bw);
    return (k / 2) * (m / (bw / 2));
  endfunction

endpackage

// File: rtl/sys_arr_out_addr_gen.sv
// Beat address generator: walks row blocks (inner) and column pairs (outer),
// and exposes the address and last-beat flag of the beat that follows the
// current one so the top can register it on the handshake edge.
module sys_arr_out_addr_gen
  import dsp_sys_arr_pkg::*;
#(
  parameter int M  = 4,
  parameter int K  = 4,
  parameter int BW = 4,
  localparam int HB  = BW / 2,
  localparam int NRB = M / HB,
  localparam int NCP = K / 2,
  localparam int RBW = (NRB > 1) ? $clog2(NRB) : 1,
  localparam int CPW = (NCP > 1) ? $clog2(NCP) : 1
) (
  input  logic           CLK,
  input  logic           nRST,
  input  logic           clear_i,
  input  logic           advance_i,
  output logic [RBW-1:0] rb_nxt_o,
  output logic [CPW-1:0] cp_nxt_o,
  output logic           nxt_last_o,
  output logic           wrap_o
);

  localparam logic [RBW-1:0] RB_MAX = RBW'(NRB - 1);
  localparam logic [CPW-1:0] CP_MAX = CPW'(NCP - 1);

  logic [RBW-1:0] rb_q, rb_d;
  logic [CPW-1:0] cp_q, cp_d;
  logic           wrap_s;

  // Next address: row block steps first, column pair steps when rows wrap.
  always_comb begin
    wrap_s = (rb_q == RB_MAX);
    rb_d   = wrap_s ? '0 : rb_q + RBW'(1);
    if (wrap_s) begin
      cp_d = (cp_q == CP_MAX) ? '0 : cp_q + CPW'(1);
    end else begin
      cp_d = cp_q;
    end
    nxt_last_o = (rb_d == RB_MAX) && (cp_d == CP_MAX);
    rb_nxt_o   = rb_d;
    cp_nxt_o   = cp_d;
    wrap_o     = wrap_s;
  end

  // Counter registers: cleared on capture, stepped on each accepted non-final beat.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      rb_q <= '0;
      cp_q <= '0;
    end else if (clear_i) begin
      rb_q <= '0;
      cp_q <= '0;
    end else if (advance_i) begin
      rb_q <= rb_d;
      cp_q <= cp_d;
    end else begin
      rb_q <= rb_q;
      cp_q <= cp_q;
    end
  end

endmodule

// File: rtl/sys_arr_out_streamer.sv
// AXI-stream drain for the systolic-array result matrix. Captures the whole
// MxK result on res_done and emits it as BW-word beats, each holding BW/2
// consecutive rows of two adjacent columns. The drain_done cycle is still
// spent in STREAM so a res_done arriving then is ignored.
module sys_arr_out_streamer
  import dsp_sys_arr_pkg::*;
#(
  parameter int M  = 4,
  parameter int K  = 4,
  parameter int BW = 4,
  parameter int DW = 32
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic [M*K*DW-1:0] res_in,
  input  logic              res_done,
  output logic [BW*DW-1:0]  out_stream,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic              busy,
  output logic              drain_done
);

  localparam int HB     = BW / 2;
  localparam int NRB    = M / HB;
  localparam int NCP    = K / 2;
  localparam int RBW    = (NRB > 1) ? $clog2(NRB) : 1;
  localparam int CPW    = (NCP > 1) ? $clog2(NCP) : 1;
  localparam int NBEATS = beats(M, K, BW);

  strm_state_t       state_q;
  logic [M*K*DW-1:0] buf_q;
  logic [BW*DW-1:0]  out_stream_q;
  logic              out_valid_q;
  logic              out_last_q;
  logic              busy_q;
  logic              drain_done_q;

  logic              capture_s;
  logic              hshk_s;
  logic              advance_s;
  logic [RBW-1:0]    rb_nxt_s;
  logic [CPW-1:0]    cp_nxt_s;
  logic              nxt_last_s;
  logic              wrap_s;

  // Gather one beat: low half is column 2*cp, high half is column 2*cp+1.
  function automatic logic [BW*DW-1:0] pack_beat(input logic [M*K*DW-1:0] src,
                                                 input int rb, input int cp);
    logic [BW*DW-1:0] beat;
    int row;
    int col;
    beat = '0;
    col  = cp * 2;
    for (int l = 0; l < HB; l++) begin
      row = rb * HB + l;
      beat[l*DW +: DW]      = src[(row*K + col)*DW +: DW];
      beat[(l+HB)*DW +: DW] = src[(row*K + col + 1)*DW +: DW];
    end
    return beat;
  endfunction

  // Control strobes derived from the current state and the handshake.
  always_comb begin
    capture_s = (state_q == IDLE) && res_done;
    hshk_s    = out_valid_q && out_ready;
    advance_s = (state_q == STREAM) && hshk_s && !out_last_q && !drain_done_q;
  end

  sys_arr_out_addr_gen #(
    .M  (M),
    .K  (K),
    .BW (BW)
  ) u_addr_gen (
    .CLK        (CLK),
    .nRST       (nRST),
    .clear_i    (capture_s),
    .advance_i  (advance_s),
    .rb_nxt_o   (rb_nxt_s),
    .cp_nxt_o   (cp_nxt_s),
    .nxt_last_o (nxt_last_s),
    .wrap_o     (wrap_s)
  );

  // Capture buffer: loaded only on an accepted res_done, never cleared.
  always_ff @(posedge CLK) begin
    if (nRST && capture_s) begin
      buf_q <= res_in;
    end else begin
      buf_q <= buf_q;
    end
  end

  // Streamer FSM with registered beat data and handshake outputs.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state_q      <= IDLE;
      out_stream_q <= '0;
      out_valid_q  <= 1'b0;
      out_last_q   <= 1'b0;
      busy_q       <= 1'b0;
      drain_done_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          drain_done_q <= 1'b0;
          if (res_done) begin
            out_stream_q <= pack_beat(res_in, 32'sd0, 32'sd0);
            out_valid_q  <= 1'b1;
            out_last_q   <= (NBEATS == 32'sd1);
            busy_q       <= 1'b1;
            state_q      <= STREAM;
          end else begin
            out_valid_q  <= 1'b0;
            out_last_q   <= 1'b0;
            busy_q       <= 1'b0;
          end
        end
        STREAM: begin
          if (drain_done_q) begin
            drain_done_q <= 1'b0;
            busy_q       <= 1'b0;
            state_q      <= IDLE;
          end else if (hshk_s) begin
            if (out_last_q) begin
              out_valid_q  <= 1'b0;
              out_last_q   <= 1'b0;
              drain_done_q <= 1'b1;
            end else begin
              out_stream_q <= pack_beat(buf_q, int'(rb_nxt_s), int'(cp_nxt_s));
              out_last_q   <= nxt_last_s;
            end
          end else begin
            out_stream_q <= out_stream_q;
            out_last_q   <= out_last_q;
          end
        end
        default: begin
          state_q     <= IDLE;
          out_valid_q <= 1'b0;
          out_last_q  <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  // The row-wrap flag is only consumed inside the address generator.
  logic unused_wrap_s;
  always_comb begin
    unused_wrap_s = wrap_s;
  end

  assign out_stream = out_stream_q;
  assign out_valid  = out_valid_q;
  assign out_last   = out_last_q;
  assign busy       = busy_q;
  assign drain_done = drain_done_q;

endmodule

// File: tb/tb_sys_arr_out_streamer.sv
// Directed and randomized bench for sys_arr_out_streamer (M=K=BW=4).
module tb_sys_arr_out_streamer;

  localparam int M  = 4;
  localparam int K  = 4;
  localparam int BW = 4;
  localparam int DW = 32;
  localparam int HB = BW / 2;
  localparam int NB = (K / 2) * (M / HB);

  logic              CLK = 1'b0;
  logic              nRST;
  logic [M*K*DW-1:0] res_in;
  logic              res_done;
  logic [BW*DW-1:0]  out_stream;
  logic              out_valid;
  logic              out_ready;
  logic              out_last;
  logic              busy;
  logic              drain_done;

  int n_chk  = 0;
  int n_fail = 0;
  logic [BW*DW-1:0] beat0_seen;

  always #5 CLK = ~CLK;

  sys_arr_out_streamer #(.M(M), .K(K), .BW(BW), .DW(DW)) dut (
    .CLK        (CLK),
    .nRST       (nRST),
    .res_in     (res_in),
    .res_done   (res_done),
    .out_stream (out_stream),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_last   (out_last),
    .busy       (busy),
    .drain_done (drain_done)
  );

  task automatic chk(input string tag, input logic [BW*DW-1:0] obs, input logic [BW*DW-1:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Single-precision encoding of a small positive integer.
  function automatic logic [31:0] f32(input int n);
    int e;
    e = 0;
    while ((n >> (e + 1)) != 0) e++;
    return {1'b0, 8'(127 + e), 23'((n - (1 << e)) << (23 - e))};
  endfunction

  // Reference: matrix view of the result, beats listed column pair outer, row block inner.
  task automatic build_beats(input logic [M*K*DW-1:0] data, output logic [BW*DW-1:0] q[$]);
    logic [DW-1:0] c [M][K];
    logic [BW*DW-1:0] b;
    q = {};
    for (int r = 0; r < M; r++)
      for (int cc = 0; cc < K; cc++)
        c[r][cc] = data[(r*K + cc)*DW +: DW];
    for (int j = 0; j < K; j += 2) begin
      for (int i = 0; i < M; i += HB) begin
        for (int l = 0; l < HB; l++) begin
          b[l*DW +: DW]      = c[i+l][j];
          b[(l+HB)*DW +: DW] = c[i+l][j+1];
        end
        q.push_back(b);
      end
    end
  endtask

  function automatic logic [M*K*DW-1:0] rand_mat();
    logic [M*K*DW-1:0] d;
    for (int n = 0; n < M*K; n++) d[n*DW +: DW] = $urandom;
    return d;
  endfunction

  // Modes: 0 ready=1, 1 five-cycle stall on beat 2, 2 alternating ready,
  // 3 res_done during streaming, 4 reset after beat 2, 5 res_done on drain_done, 6 random ready.
  task automatic drain(input logic [M*K*DW-1:0] data, input int mode);
    logic [BW*DW-1:0] q[$];
    logic [BW*DW-1:0] held;
    logic held_last;
    logic prev_stall;
    logic rdy;
    logic alt;
    int acc;
    int cyc;
    int stall;
    build_beats(data, q);
    acc = 0; cyc = 0; stall = 0; prev_stall = 1'b0; alt = 1'b1;
    held = '0; held_last = 1'b0;
    res_in   = data;
    res_done = 1'b1;
    chk("valid_idle", out_valid, 1'b0);
    @(negedge CLK);
    res_done   = 1'b0;
    res_in     = rand_mat();
    beat0_seen = out_stream;
    chk("busy_start", busy, 1'b1);
    while (acc < NB && cyc < 40) begin
      chk("valid_held", out_valid, 1'b1);
      if (mode == 3) chk("busy_during", busy, 1'b1);
      if (prev_stall) begin
        chk("stall_data", out_stream, held);
        chk("stall_last", out_last, held_last);
      end
      case (mode)
        1:       rdy = !(acc == 1 && stall < 5);
        2:       begin rdy = alt; alt = !alt; end
        6:       rdy = (cyc > 30) ? 1'b1 : 1'($urandom_range(0, 1));
        default: rdy = 1'b1;
      endcase
      if (mode == 1 && !rdy) stall++;
      res_done = (mode == 3 && cyc == 0);
      if (mode == 3 && cyc == 0) res_in = '0;
      out_ready = rdy;
      if (out_valid && rdy) begin
        chk($sformatf("beat%0d", acc), out_stream, q[acc]);
        chk($sformatf("last%0d", acc), out_last, (acc == NB - 1));
        acc++;
      end
      prev_stall = out_valid && !rdy;
      held       = out_stream;
      held_last  = out_last;
      @(negedge CLK);
      res_done = 1'b0;
      cyc++;
      if (mode == 4 && acc == 2) begin
        nRST      = 1'b0;
        out_ready = 1'b0;
        @(negedge CLK);
        chk("rst_valid", out_valid, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", drain_done, 1'b0);
        chk("rst_last", out_last, 1'b0);
        chk("rst_data", out_stream, '0);
        nRST = 1'b1;
        return;
      end
    end
    chk("beats_accepted", acc, NB);
    if (mode == 1) chk("stall_cycles", stall, 5);
    if (mode == 2) chk("alt_cycles", cyc, 7);
    if (mode == 0) chk("burst_cycles", cyc, 4);
    chk("done_pulse", drain_done, 1'b1);
    chk("done_valid", out_valid, 1'b0);
    chk("done_last", out_last, 1'b0);
    chk("done_busy", busy, 1'b1);
    if (mode == 5) begin
      res_in   = rand_mat();
      res_done = 1'b1;
    end
    @(negedge CLK);
    res_done = 1'b0;
    chk("done_clear", drain_done, 1'b0);
    chk("idle_busy", busy, 1'b0);
    chk("idle_valid", out_valid, 1'b0);
  endtask

  initial begin
    logic [M*K*DW-1:0] fdata;
    nRST      = 1'b0;
    res_done  = 1'b0;
    res_in    = '0;
    out_ready = 1'b0;
    repeat (2) @(negedge CLK);
    chk("reset_valid", out_valid, 1'b0);
    chk("reset_last", out_last, 1'b0);
    chk("reset_busy", busy, 1'b0);
    chk("reset_done", drain_done, 1'b0);
    chk("reset_data", out_stream, '0);
    nRST = 1'b1;
    @(negedge CLK);

    for (int n = 0; n < M*K; n++) fdata[n*DW +: DW] = f32(n + 1);

    drain(fdata, 0);
    chk("beat0_word0", beat0_seen[31:0], 32'h3F80_0000);
    chk("beat0_words", beat0_seen, {f32(6), f32(2), f32(5), f32(1)});
    drain(fdata, 1);
    drain(fdata, 2);
    drain(fdata, 3);
    drain(fdata, 4);
    drain(fdata, 0);
    chk("restart_beat0", beat0_seen, {f32(6), f32(2), f32(5), f32(1)});
    drain(fdata, 5);
    drain(rand_mat(), 0);
    drain(rand_mat(), 6);
    drain(rand_mat(), 6);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
